// File: rtl/cpu6502_pkg.sv
// Shared types and constants for the 6502/6507 front end: fetch sequencer
// states, locally executed opcodes and the hardware vector addresses.
package cpu6502_pkg;

  typedef enum logic [3:0] {
    ST_RST_L,
    ST_RST_H,
    ST_FETCH,
    ST_NOP_W,
    ST_JA_L,
    ST_JA_H,
    ST_JI_L,
    ST_JI_H,
    ST_JI_PL,
    ST_JI_PH,
    ST_HAND
  } fetch_state_t;

  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_JMP_IND = 8'h6C;
  localparam logic [7:0] OP_NOP     = 8'hEA;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

endpackage

// File: rtl/cpu6502_pc.sv
// 16-bit program counter: load has priority over increment, otherwise holds.
// Increment wraps naturally from FFFF to 0000.
module cpu6502_pc (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        ld,
  input  logic [15:0] ld_val,
  output logic [15:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= 16'h0000;
    end else if (ld) begin
      pc <= ld_val;
    end else if (inc) begin
      pc <= pc + 16'd1;
    end
  end

endmodule

// File: rtl/cpu6502_fetch_seq.sv
// Program-counter / instruction-fetch sequencer: reset vector, opcode fetch,
// local JMP abs / JMP ind / NOP, and valid/ready handoff of other opcodes.
// Define CPU6502_JMP_IND_PAGE_BUG_EN to reproduce the NMOS JMP (ind) page wrap.
module cpu6502_fetch_seq
  import cpu6502_pkg::*;
#(
  parameter int          ADDR_W    = 13,
  parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic [ADDR_W-1:0] Addr,
  output logic              R_W,
  input  logic [7:0]        Din,
  input  logic              rdy,
  output logic              sync,
  output logic              op_valid,
  output logic [7:0]        op_code,
  output logic [15:0]       op_pc,
  input  logic              op_ready,
  input  logic              pc_ld,
  input  logic [15:0]       pc_ld_val
);

  fetch_state_t state, state_next;
  logic [7:0]   ir, ir_next;
  logic [7:0]   tmp, tmp_next;
  logic [15:0]  ptr, ptr_d;
  logic [15:0]  ptr_inc;
  logic [15:0]  pc;
  logic         pc_inc_en;
  logic         pc_load_en;
  logic [15:0]  pc_load_val;
  logic [15:0]  addr_full;

`ifdef CPU6502_JMP_IND_PAGE_BUG_EN
  assign ptr_inc = {ptr[15:8], ptr[7:0] + 8'd1};
`else
  assign ptr_inc = ptr + 16'd1;
`endif

  cpu6502_pc u_pc (
    .clk    (Clk),
    .reset  (Reset),
    .inc    (pc_inc_en),
    .ld     (pc_load_en),
    .ld_val (pc_load_val),
    .pc     (pc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_RST_L;
      ir    <= 8'h00;
      tmp   <= 8'h00;
      ptr   <= 16'h0000;
    end else begin
      state <= state_next;
      ir    <= ir_next;
      tmp   <= tmp_next;
      ptr   <= ptr_d;
    end
  end

  // Every read state waits on rdy; only the handoff state ignores it.
  always_comb begin
    state_next  = state;
    ir_next     = ir;
    tmp_next    = tmp;
    ptr_d       = ptr;
    pc_inc_en   = 1'b0;
    pc_load_en  = 1'b0;
    pc_load_val = pc;
    addr_full   = pc;
    case (state)
      ST_RST_L: begin
        addr_full = RESET_VEC;
        if (rdy) begin
          tmp_next   = Din;
          state_next = ST_RST_H;
        end
      end
      ST_RST_H: begin
        addr_full = RESET_VEC + 16'd1;
        if (rdy) begin
          pc_load_en  = 1'b1;
          pc_load_val = {Din, tmp};
          state_next  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (rdy) begin
          ir_next   = Din;
          pc_inc_en = 1'b1;
          case (Din)
            OP_JMP_ABS: state_next = ST_JA_L;
            OP_JMP_IND: state_next = ST_JI_L;
            OP_NOP:     state_next = ST_NOP_W;
            default:    state_next = ST_HAND;
          endcase
        end
      end
      ST_NOP_W: begin
        if (rdy) begin
          state_next = ST_FETCH;
        end
      end
      ST_JA_L, ST_JI_L: begin
        if (rdy) begin
          tmp_next   = Din;
          pc_inc_en  = 1'b1;
          state_next = (state == ST_JA_L) ? ST_JA_H : ST_JI_H;
        end
      end
      ST_JA_H: begin
        if (rdy) begin
          pc_load_en  = 1'b1;
          pc_load_val = {Din, tmp};
          state_next  = ST_FETCH;
        end
      end
      ST_JI_H: begin
        if (rdy) begin
          ptr_d      = {Din, tmp};
          state_next = ST_JI_PL;
        end
      end
      ST_JI_PL: begin
        addr_full = ptr;
        if (rdy) begin
          tmp_next   = Din;
          state_next = ST_JI_PH;
        end
      end
      ST_JI_PH: begin
        addr_full = ptr_inc;
        if (rdy) begin
          pc_load_en  = 1'b1;
          pc_load_val = {Din, tmp};
          state_next  = ST_FETCH;
        end
      end
      ST_HAND: begin
        if (op_ready) begin
          pc_load_en  = pc_ld;
          pc_load_val = pc_ld_val;
          state_next  = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_RST_L;
      end
    endcase
  end

  assign Addr     = ADDR_W'(addr_full);
  assign R_W      = 1'b1;
  assign sync     = (state == ST_FETCH);
  assign op_valid = (state == ST_HAND);
  assign op_code  = ir;
  assign op_pc    = pc;

endmodule

// File: tb/tb_cpu6502_fetch_seq.sv
// Self-checking bench for cpu6502_fetch_seq: instruction-level model of the
// fetch sequencer driving a 64 KiB memory, with random rdy stalls and opcodes.
module tb_cpu6502_fetch_seq;

  localparam int AW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        r_w;
  logic [7:0]  din;
  logic        rdy;
  logic        sync;
  logic        op_valid;
  logic [7:0]  op_code;
  logic [15:0] op_pc;
  logic        op_ready;
  logic        pc_ld;
  logic [15:0] pc_ld_val;

  logic [7:0]  mem [0:65535];
  logic [15:0] mpc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign din = mem[addr];

  cpu6502_fetch_seq #(
    .ADDR_W    (AW),
    .RESET_VEC (16'hFFFC)
  ) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Addr      (addr),
    .R_W       (r_w),
    .Din       (din),
    .rdy       (rdy),
    .sync      (sync),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .op_pc     (op_pc),
    .op_ready  (op_ready),
    .pc_ld     (pc_ld),
    .pc_ld_val (pc_ld_val)
  );

  function automatic logic [15:0] ptr_next_of(input logic [15:0] p);
`ifdef CPU6502_JMP_IND_PAGE_BUG_EN
    return {p[15:8], p[7:0] + 8'd1};
`else
    return p + 16'd1;
`endif
  endfunction

  function automatic bit in_instr(input logic [15:0] x, input logic [15:0] p);
    return (x == p) || (x == p + 16'd1) || (x == p + 16'd2);
  endfunction

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One read cycle expected at address a; stalls<0 picks random rdy stalls.
  task automatic apply_cycle(input logic [15:0] a, input logic s, input int stalls, input string tag);
    int n = 0;
    bit done = 1'b0;
    bit r;
    while (!done) begin
      check_output({tag, ".addr"}, addr, a);
      check_output({tag, ".sync"}, 16'(sync), 16'(s));
      check_output({tag, ".valid"}, 16'(op_valid), 16'h0000);
      if (stalls >= 0) r = (n >= stalls);
      else             r = (n >= 3) || ($urandom_range(0, 3) != 0);
      rdy = r;
      n++;
      @(negedge clk);
      done = r;
    end
    rdy = 1'b1;
  endtask

  task automatic do_nop();
    logic [15:0] p = mpc;
    mem[p] = 8'hEA;
    apply_cycle(p, 1'b1, -1, "nop.fetch");
    apply_cycle(p + 16'd1, 1'b0, -1, "nop.dummy");
    mpc = p + 16'd1;
  endtask

  task automatic do_jabs(input logic [15:0] tgt, input int stall_hi);
    logic [15:0] p = mpc;
    mem[p] = 8'h4C;
    mem[p + 16'd1] = tgt[7:0];
    mem[p + 16'd2] = tgt[15:8];
    apply_cycle(p, 1'b1, -1, "jabs.fetch");
    apply_cycle(p + 16'd1, 1'b0, -1, "jabs.lo");
    apply_cycle(p + 16'd2, 1'b0, stall_hi, "jabs.hi");
    mpc = tgt;
  endtask

  task automatic reset_now(input string tag);
    logic [15:0] vec = 16'($urandom);
    mem[16'hFFFC] = vec[7:0];
    mem[16'hFFFD] = vec[15:8];
    rdy = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_output({tag, ".valid"}, 16'(op_valid), 16'h0000);
    check_output({tag, ".sync"}, 16'(sync), 16'h0000);
    check_output({tag, ".addr"}, addr, 16'hFFFC);
    @(negedge clk);
    check_output({tag, ".held"}, addr, 16'hFFFC);
    reset = 1'b0;
    apply_cycle(16'hFFFC, 1'b0, -1, "rst.lo");
    apply_cycle(16'hFFFD, 1'b0, -1, "rst.hi");
    mpc = vec;
  endtask

  // Pointer bytes must already be in mem; abort resets the DUT in JI_PL.
  task automatic do_jind(input logic [15:0] ptr, input bit abort);
    logic [15:0] p = mpc;
    logic [15:0] pn = ptr_next_of(ptr);
    logic [15:0] tgt;
    mem[p] = 8'h6C;
    mem[p + 16'd1] = ptr[7:0];
    mem[p + 16'd2] = ptr[15:8];
    tgt = {mem[pn], mem[ptr]};
    apply_cycle(p, 1'b1, -1, "jind.fetch");
    apply_cycle(p + 16'd1, 1'b0, -1, "jind.lo");
    apply_cycle(p + 16'd2, 1'b0, -1, "jind.hi");
    if (abort) begin
      check_output("jind.abort.ptr", addr, ptr);
      reset_now("rst.jipl");
    end else begin
      apply_cycle(ptr, 1'b0, -1, "jind.plo");
      apply_cycle(pn, 1'b0, -1, "jind.phi");
      mpc = tgt;
    end
  endtask

  task automatic do_hand(input logic [7:0] opc, input int nwait, input bit ld, input logic [15:0] val);
    logic [15:0] p = mpc;
    mem[p] = opc;
    apply_cycle(p, 1'b1, -1, "hand.fetch");
    for (int i = 0; i <= nwait; i++) begin
      check_output("hand.valid", 16'(op_valid), 16'h0001);
      check_output("hand.code", 16'(op_code), 16'(opc));
      check_output("hand.pc", op_pc, p + 16'd1);
      check_output("hand.addr", addr, p + 16'd1);
      check_output("hand.sync", 16'(sync), 16'h0000);
      rdy = 1'($urandom);
      if (i < nwait) begin
        op_ready  = 1'b0;
        pc_ld     = 1'($urandom);
        pc_ld_val = 16'($urandom);
      end else begin
        op_ready  = 1'b1;
        pc_ld     = ld;
        pc_ld_val = val;
      end
      @(negedge clk);
    end
    op_ready = 1'b0;
    pc_ld    = 1'b0;
    rdy      = 1'b1;
    mpc = ld ? val : p + 16'd1;
  endtask

  function automatic logic [7:0] rand_other_op();
    logic [7:0] o;
    do o = 8'($urandom); while (o == 8'h4C || o == 8'h6C || o == 8'hEA);
    return o;
  endfunction

  initial begin
    logic [15:0] rp;
    logic [15:0] rpn;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'hF0;
    reset     = 1'b1;
    rdy       = 1'b1;
    op_ready  = 1'b0;
    pc_ld     = 1'b0;
    pc_ld_val = 16'h0000;

    @(negedge clk);
    check_output("reset.addr", addr, 16'hFFFC);
    check_output("reset.sync", 16'(sync), 16'h0000);
    check_output("reset.valid", 16'(op_valid), 16'h0000);
    check_output("reset.rw", 16'(r_w), 16'h0001);
    @(negedge clk);
    reset = 1'b0;
    apply_cycle(16'hFFFC, 1'b0, 0, "vec.lo");
    apply_cycle(16'hFFFD, 1'b0, 0, "vec.hi");
    mpc = 16'hF000;

    do_jabs(16'hF234, 3);
    do_hand(8'hA9, 5, 1'b1, 16'h1000);
    mem[16'h02FF] = 8'h00;
    mem[16'h0200] = 8'hF1;
    mem[16'h0300] = 8'hF4;
    do_jind(16'h02FF, 1'b0);
    do_hand(rand_other_op(), 2, 1'b0, 16'h0000);
    do_hand(rand_other_op(), 1, 1'b1, 16'hFFFF);
    do_nop();
    check_output("r_w.const", 16'(r_w), 16'h0001);

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: do_nop();
        1: do_jabs(16'($urandom), -1);
        2: begin
          do begin
            rp  = 16'($urandom);
            rpn = ptr_next_of(rp);
          end while (in_instr(rp, mpc) || in_instr(rpn, mpc));
          mem[rp]  = 8'($urandom);
          mem[rpn] = 8'($urandom);
          do_jind(rp, 1'b0);
        end
        default: do_hand(rand_other_op(), $urandom_range(0, 4), 1'($urandom), 16'($urandom));
      endcase
    end

    mem[mpc] = 8'hA9;
    apply_cycle(mpc, 1'b1, -1, "hrst.fetch");
    check_output("hrst.valid", 16'(op_valid), 16'h0001);
    reset_now("rst.hand");

    do begin
      rp  = 16'($urandom);
      rpn = ptr_next_of(rp);
    end while (in_instr(rp, mpc) || in_instr(rpn, mpc) || rp == 16'hFFFC || rp == 16'hFFFD);
    do_jind(rp, 1'b1);
    do_nop();
    do_jabs(16'($urandom), -1);
    apply_cycle(mpc, 1'b1, 0, "final.fetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
